// File: rtl/npc_irq.sv
// Next-PC selection with a small interrupt controller (edge-detected lines, lowest-index priority, mret return).
// Build option: define NPC_VECTORED_EN for per-channel vectors (INT_BASE + 4*channel); otherwise all channels share INT_BASE.
module npc_irq #(
    parameter int               XLEN     = 32,
    parameter int               NUM_IRQ  = 4,
    parameter logic [XLEN-1:0]  INT_BASE = XLEN'(32'h0000_0100)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     alu_out,
    input  logic [2:0]          npc_op,
    input  logic                stall,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                irq_en,
    input  logic                mret,
    output logic [XLEN-1:0]     npc,
    output logic                int_taken,
    output logic [3:0]          int_cause,
    output logic [XLEN-1:0]     epc,
    output logic                in_isr
);

    typedef enum logic {
        IDLE = 1'b0,
        ISR  = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [NUM_IRQ-1:0]  irq_d_reg;
    logic [NUM_IRQ-1:0]  pending_reg, pending_next;
    logic [NUM_IRQ-1:0]  irq_edge;
    logic [NUM_IRQ-1:0]  take_onehot;
    logic [NUM_IRQ-1:0]  take_mask;
    logic [XLEN-1:0]     epc_reg;
    logic [XLEN-1:0]     base_target;
    logic [XLEN-1:0]     vector;
    logic [3:0]          int_cause_reg;
    logic [3:0]          winner;
    logic                int_taken_reg;
    logic                take;
    logic                found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
            assign irq_edge[gi]  = irq_in[gi] & ~irq_d_reg[gi];
            assign take_mask[gi] = take & take_onehot[gi];
        end
    endgenerate

    always_comb begin
        base_target = pc + XLEN'(4);
        case (npc_op)
            3'b001, 3'b010: base_target = pc_in + imm;
            3'b100:         base_target = alu_out;
            default:        base_target = stall ? pc : pc + XLEN'(4);
        endcase
    end

    // Lowest set pending index wins.
    always_comb begin
        winner      = 4'd0;
        take_onehot = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending_reg[i] && !found) begin
                winner         = 4'(i);
                take_onehot[i] = 1'b1;
                found          = 1'b1;
            end
        end
    end

`ifdef NPC_VECTORED_EN
    assign vector = INT_BASE + (XLEN'(winner) << 2);
`else
    assign vector = INT_BASE;
`endif

    // While reset is asserted the interrupt paths are masked so npc is the plain base target.
    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        npc        = base_target;
        if (rstn) begin
            case (state_reg)
                IDLE: begin
                    if (irq_en && !stall && found) begin
                        take       = 1'b1;
                        npc        = vector;
                        state_next = ISR;
                    end
                end
                ISR: begin
                    if (mret) begin
                        if (stall) begin
                            npc = pc;
                        end else begin
                            npc        = epc_reg;
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A fresh edge on the channel being taken survives because irq_edge is OR-ed after the clear.
    assign pending_next = (pending_reg & ~take_mask) | irq_edge;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            irq_d_reg     <= '0;
            epc_reg       <= '0;
            int_cause_reg <= 4'd0;
            int_taken_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            irq_d_reg     <= irq_in;
            int_taken_reg <= take;
            if (take) begin
                epc_reg       <= base_target;
                int_cause_reg <= winner;
            end
        end
    end

    assign int_taken = int_taken_reg;
    assign int_cause = int_cause_reg;
    assign epc       = epc_reg;
    assign in_isr    = (state_reg == ISR);

endmodule

// File: tb/tb_npc_irq.sv
// Directed-vector bench for npc_irq: the driver queues the expected per-cycle outputs, a negedge monitor checks them.
module tb_npc_irq;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc, pc_in, imm, alu_out;
    logic [2:0]  npc_op;
    logic        stall;
    logic [3:0]  irq_in;
    logic        irq_en;
    logic        mret;
    logic [31:0] npc;
    logic        int_taken;
    logic [3:0]  int_cause;
    logic [31:0] epc;
    logic        in_isr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic        isr;
        logic        taken;
        logic        chk_regs;
        logic [31:0] epc;
        logic [3:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    npc_irq dut (
        .clk       (clk),
        .rstn      (rstn),
        .pc        (pc),
        .pc_in     (pc_in),
        .imm       (imm),
        .alu_out   (alu_out),
        .npc_op    (npc_op),
        .stall     (stall),
        .irq_in    (irq_in),
        .irq_en    (irq_en),
        .mret      (mret),
        .npc       (npc),
        .int_taken (int_taken),
        .int_cause (int_cause),
        .epc       (epc),
        .in_isr    (in_isr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vec(input int ch);
`ifdef NPC_VECTORED_EN
        return 32'h100 + 32'(ch) * 32'd4;
`else
        return 32'h100 + 32'(ch) * 32'd0;
`endif
    endfunction

    // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (npc !== mon_e.npc) begin
                n_fail++;
                $display("FAIL %s npc: got %h expected %h", mon_e.name, npc, mon_e.npc);
            end
            n_checks++;
            if (in_isr !== mon_e.isr) begin
                n_fail++;
                $display("FAIL %s in_isr: got %b expected %b", mon_e.name, in_isr, mon_e.isr);
            end
            n_checks++;
            if (int_taken !== mon_e.taken) begin
                n_fail++;
                $display("FAIL %s int_taken: got %b expected %b", mon_e.name, int_taken, mon_e.taken);
            end
            if (mon_e.chk_regs) begin
                n_checks++;
                if (epc !== mon_e.epc) begin
                    n_fail++;
                    $display("FAIL %s epc: got %h expected %h", mon_e.name, epc, mon_e.epc);
                end
                n_checks++;
                if (int_cause !== mon_e.cause) begin
                    n_fail++;
                    $display("FAIL %s int_cause: got %0d expected %0d", mon_e.name, int_cause, mon_e.cause);
                end
            end
            $display("cycle %-14s npc=%h in_isr=%b taken=%b epc=%h cause=%0d",
                     mon_e.name, npc, in_isr, int_taken, epc, int_cause);
        end
    end

    // Inputs are already applied; queue the expectation and advance one clock.
    task automatic cyc(input string name, input logic [31:0] e_npc, input logic e_isr,
                       input logic e_taken, input logic chk, input logic [31:0] e_epc,
                       input logic [3:0] e_cause);
        exp_t e;
        e.name = name; e.npc = e_npc; e.isr = e_isr; e.taken = e_taken;
        e.chk_regs = chk; e.epc = e_epc; e.cause = e_cause;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; pc = 32'h20; pc_in = 32'h0; imm = 32'h0; alu_out = 32'h0;
        npc_op = 3'b000; stall = 1'b0; irq_in = 4'b0000; irq_en = 1'b1; mret = 1'b0;
        @(posedge clk);
        #1;

        // Reset state; a line raised during reset and held through release.
        cyc("reset0", 32'h24, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
        irq_in = 4'b0010;
        cyc("reset1_irq", 32'h24, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
        rstn = 1'b1;
        cyc("rel_edge", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("rel_take1", vec(1), 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("rel_isr", 32'h24, 1'b1, 1'b1, 1'b1, 32'h24, 4'd1);
        mret = 1'b1;
        cyc("rel_mret", 32'h24, 1'b1, 1'b0, 1'b1, 32'h24, 4'd1);
        mret = 1'b0;
        cyc("rel_idle_a", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("rel_idle_b", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        irq_in = 4'b0000;

        // Base target decoding, including wraparound and an undefined opcode.
        npc_op = 3'b001; pc_in = 32'h40; imm = 32'h10;
        cyc("branch", 32'h50, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        npc_op = 3'b010; pc_in = 32'hFFFF_FFF0; imm = 32'h20;
        cyc("jump_wrap", 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        npc_op = 3'b100; alu_out = 32'h1234;
        cyc("jalr", 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        npc_op = 3'b011;
        cyc("op_undef", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        npc_op = 3'b000; stall = 1'b1;
        cyc("plus4_stall", 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        stall = 1'b0;

        // Single interrupt on channel 2, then mret held by stall.
        irq_in = 4'b0100;
        cyc("irq2_edge", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("irq2_take", vec(2), 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("irq2_isr", 32'h24, 1'b1, 1'b1, 1'b1, 32'h24, 4'd2);
        pc = 32'h80; mret = 1'b1; stall = 1'b1;
        cyc("mret_stall", 32'h80, 1'b1, 1'b0, 1'b1, 32'h24, 4'd2);
        stall = 1'b0;
        cyc("mret_go", 32'h24, 1'b1, 1'b0, 1'b1, 32'h24, 4'd2);
        mret = 1'b0;
        cyc("after_mret", 32'h84, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        mret = 1'b1;
        cyc("mret_idle", 32'h84, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        mret = 1'b0; pc = 32'h20; irq_in = 4'b0000;
        cyc("mret_ignored", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);

        // Simultaneous edges on 1 and 3: priority, then the deferred channel.
        irq_in = 4'b1010;
        cyc("dual_edge", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("dual_take1", vec(1), 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("dual_isr1", 32'h24, 1'b1, 1'b1, 1'b1, 32'h24, 4'd1);
        mret = 1'b1;
        cyc("dual_mret1", 32'h24, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0);
        mret = 1'b0;
        cyc("dual_take3", vec(3), 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        cyc("dual_isr3", 32'h24, 1'b1, 1'b1, 1'b1, 32'h24, 4'd3);
        mret = 1'b1;
        cyc("dual_mret3", 32'h24, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0);
        mret = 1'b0; irq_in = 4'b0000;
        cyc("dual_done", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);

        // Disabled interrupts are delayed, not lost.
        irq_en = 1'b0; irq_in = 4'b0001;
        cyc("dis_edge", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        for (int k = 0; k < 5; k++)
            cyc("dis_wait", 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        irq_en = 1'b1;
        cyc("en_take0", vec(0), 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        irq_in = 4'b1001;
        cyc("en_isr0", 32'h24, 1'b1, 1'b1, 1'b1, 32'h24, 4'd0);
        cyc("isr_pend3", 32'h24, 1'b1, 1'b0, 1'b1, 32'h24, 4'd0);

        // Reset mid-ISR with channel 3 pending.
        rstn = 1'b0; irq_in = 4'b0000;
        cyc("rst_in_isr", 32'h24, 1'b1, 1'b0, 1'b1, 32'h24, 4'd0);
        cyc("rst_hold", 32'h24, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
        rstn = 1'b1;
        cyc("rst_rel_a", 32'h24, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
        cyc("rst_rel_b", 32'h24, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);

        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_irq.md
NPC_IRQ -- requirements
Module: npc_irq

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter NUM_IRQ, default 4, interrupt channel count, legal 1..16.
REQ-003 Parameter INT_BASE, default 32'h0000_0100, interrupt vector base address.
REQ-004 clk  in  1  single clock, rising-edge.
REQ-005 rstn  in  1  synchronous active-low reset.
REQ-006 pc  in  XLEN  current fetch PC.
REQ-007 pc_in  in  XLEN  branch/jump base PC from decode stage.
REQ-008 imm  in  XLEN  branch/jump immediate.
REQ-009 alu_out  in  XLEN  JALR target.
REQ-010 npc_op  in  3  PLUS4=000, BRANCH=001, JUMP=010, JALR=100; other codes act as PLUS4.
REQ-011 stall  in  1  pipeline stall, PC hold.
REQ-012 irq_in  in  NUM_IRQ  level interrupt lines, edge-detected internally.
REQ-013 irq_en  in  1  global interrupt enable.
REQ-014 mret  in  1  return-from-interrupt request.
REQ-015 npc  out  XLEN  next PC, combinational.
REQ-016 int_taken  out  1  registered one-cycle pulse after an interrupt is taken.
REQ-017 int_cause  out  4  registered index of last taken channel.
REQ-018 epc  out  XLEN  registered saved return address.
REQ-019 in_isr  out  1  high while state is ISR.

Function
REQ-020 Base target: PLUS4 -> stall ? pc : pc+4; BRANCH/JUMP -> pc_in+imm; JALR -> alu_out; all sums modulo 2^XLEN.
REQ-021 Edge detect: edge[i] = irq_in[i] & ~irq_d[i], irq_d registered every cycle.
REQ-022 pending_next = (pending | edge) & ~take_onehot, except a new edge on the channel being taken keeps that bit set.
REQ-023 State machine: IDLE and ISR only.
REQ-024 Take condition: state IDLE, irq_en=1, stall=0, pending nonzero; winner is lowest set index.
REQ-025 Take cycle: npc = vector; epc <= base target; int_cause <= winner; pending bit cleared; state -> ISR; int_taken=1 next cycle.
REQ-026 In ISR, no interrupt is taken; pending still accumulates.
REQ-027 In ISR with mret=1 and stall=0: npc = epc; state -> IDLE next cycle.
REQ-028 mret with stall=1 is held: npc = pc, state unchanged.
REQ-029 mret in IDLE is ignored; npc = base target.
REQ-030 Take and mret never coincide, since take requires IDLE and mret acts only in ISR.
REQ-031 irq_en low delays a take; pending bits are never lost.

Reset
REQ-032 rstn=0 at a clock edge: state IDLE, pending 0, irq_d 0, epc 0, int_cause 0, int_taken 0.
REQ-033 Reset applied mid-ISR abandons the ISR and returns to IDLE.
REQ-034 A line held high through reset release registers exactly one edge.
REQ-035 During reset, npc follows base-target logic only.

Configuration
REQ-036 Macro NPC_VECTORED_EN.
- Defined: vector = INT_BASE + 4*winner.
- Undefined: vector = INT_BASE for all channels; software reads int_cause.

Verification
REQ-037 npc_op=001, pc_in=0x40, imm=0x10, no IRQ -> npc=0x50.
REQ-038 pc=0x20, op=000, irq_en=1, edge on irq_in[2] -> next cycle npc=0x108 (vectored) or 0x100 (direct); then epc=0x24, int_cause=2, int_taken one pulse.
REQ-039 Edges on channels 1 and 3 in the same cycle -> channel 1 taken; after mret, channel 3 taken.
REQ-040 In ISR with epc=0x24: mret with stall=1 -> npc=pc; stall drops -> npc=0x24, in_isr=0 next cycle.
REQ-041 irq_en=0, edge on irq_in[0], wait 5 cycles, then irq_en=1 -> taken on the first enabled cycle.
REQ-042 rstn=0 while in ISR with pending=4'b1000 -> all registers zero, state IDLE, no take.
